// File: rtl/taglist_player.sv
// taglist_player: fetches a taglist entry by sequence number and steps a ROM address range.
// Optional replay of the range while loop=1 is enabled by defining TAGLIST_PLAYER_LOOP_EN.
module taglist_player #(
    parameter int STEP_DIV = 1
) (
    input  logic        clk_1KHz,
    input  logic        reset,
    input  logic        start,
    input  logic [6:0]  seqSel,
`ifdef TAGLIST_PLAYER_LOOP_EN
    input  logic        loop,
`endif
    output logic [6:0]  ramAddr,
    input  logic [31:0] ramData,
    output logic [9:0]  romAddr,
    output logic        romValid,
    output logic        busy,
    output logic        done,
    output logic        lastRom,
    output logic        error
);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, CHECK, PLAY, FIN} state_t;
    state_t state, state_nx;
    logic [6:0] sel, seq_num;
    logic [3:0] pad;
    logic [9:0] first, last;
    logic       flag;
    logic [7:0] div;
    logic       bad, step_end, rep;
`ifdef TAGLIST_PLAYER_LOOP_EN
    assign rep = loop;
`else
    assign rep = 1'b0;
`endif
    assign bad      = pad != 4'd0 || seq_num != sel || first > last;
    assign step_end = div == 8'(STEP_DIV - 1);
    assign romValid = state == PLAY;
    assign busy     = state != IDLE;
    assign done     = state == FIN;
    assign lastRom  = done & flag;
    assign error    = state == CHECK && bad;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? FETCH : IDLE;
            FETCH:   state_nx = WAIT;
            WAIT:    state_nx = CHECK;
            CHECK:   state_nx = bad ? IDLE : PLAY;
            PLAY:    state_nx = step_end && romAddr == last && !rep ? FIN : PLAY;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk_1KHz or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end
    // Datapath: romAddr only moves in CHECK/PLAY so it holds once playback ends.
    always_ff @(posedge clk_1KHz or posedge reset) begin
        if (reset) begin
            sel     <= '0;
            ramAddr <= '0;
            {pad, seq_num, first, last, flag} <= '0;
            romAddr <= '0;
            div     <= '0;
        end else begin
            if (state == IDLE && start) begin
                sel     <= seqSel;
                ramAddr <= seqSel;
            end
            if (state == WAIT) {pad, seq_num, first, last, flag} <= ramData;
            if (state == CHECK && !bad) begin
                romAddr <= first;
                div     <= '0;
            end
            if (state == PLAY) begin
                div <= step_end ? 8'd0 : div + 8'd1;
                if (step_end && romAddr != last) romAddr <= romAddr + 10'd1;
                else if (step_end && rep)        romAddr <= first;
            end
        end
    end
endmodule

// File: tb/tb_taglist_player.sv
// tb_taglist_player: scoreboard bench for taglist_player with STEP_DIV=1 and STEP_DIV=3 instances.
module tb_taglist_player;
    typedef struct packed {logic [15:0] c; logic [1:0] k; logic [9:0] v;} ev_t;
    logic clk = 0, reset = 1, start1 = 0, start3 = 0, loop = 0;
    logic [6:0] seqSel = 0, ra1, ra3;
    logic [31:0] rd1 = 0, rd3 = 0;
    logic [9:0] ro1, ro3;
    logic rv1, bz1, dn1, lr1, er1, rv3, bz3, dn3, lr3, er3;
    logic [31:0] mem [128];
    ev_t q1[$], q3[$];
    int cyc = 0, total = 0, passed = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rd1 <= mem[ra1];
    always @(posedge clk) rd3 <= mem[ra3];

    taglist_player #(.STEP_DIV(1)) u1 (.clk_1KHz(clk), .reset(reset), .start(start1), .seqSel(seqSel),
`ifdef TAGLIST_PLAYER_LOOP_EN
        .loop(loop),
`endif
        .ramAddr(ra1), .ramData(rd1), .romAddr(ro1), .romValid(rv1), .busy(bz1), .done(dn1),
        .lastRom(lr1), .error(er1));
    taglist_player #(.STEP_DIV(3)) u3 (.clk_1KHz(clk), .reset(reset), .start(start3), .seqSel(seqSel),
`ifdef TAGLIST_PLAYER_LOOP_EN
        .loop(1'b0),
`endif
        .ramAddr(ra3), .ramData(rd3), .romAddr(ro3), .romValid(rv3), .busy(bz3), .done(dn3),
        .lastRom(lr3), .error(er3));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else passed++;
    endtask

    function automatic ev_t mk(input int c, input int k, input int v);
        return ev_t'{16'(c), 2'(k), 10'(v)};
    endfunction

    task automatic push(input bit d3, input ev_t e);
        if (d3) q3.push_back(e);
        else    q1.push_back(e);
    endtask

    task automatic push_play(input bit d3, input int s, input int f, input int l, input int d,
                             input int passes, input int flag);
        int t = s + 4;
        for (int p = 0; p < passes; p++)
            for (int a = f; a <= l; a++)
                for (int k = 0; k < d; k++) begin
                    push(d3, mk(t, 0, a));
                    t++;
                end
        push(d3, mk(t, 1, flag));
    endtask

    task automatic go(input bit d3, input logic [6:0] sel, output int s);
        @(negedge clk);
        seqSel = sel;
        if (d3) start3 = 1;
        else    start1 = 1;
        s = cyc;
        @(negedge clk);
        start1 = 0;
        start3 = 0;
    endtask

    task automatic wait_idle(input bit d3);
        int i;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!(d3 ? bz3 : bz1)) break;
        end
        if (i == 200) chk("idle_timeout", 1, 0);
    endtask

    task automatic cmp(input string nm, input ev_t e, input ev_t g);
        total++;
        if (e !== g)
            $display("FAIL %s: got cyc=%0d kind=%0d val=%0d expected cyc=%0d kind=%0d val=%0d",
                     nm, g.c, g.k, g.v, e.c, e.k, e.v);
        else passed++;
    endtask

    always @(negedge clk) if (rv1 || dn1 || er1) begin
        chk("excl1", {31'd0, dn1 & er1}, 0);
        if (q1.size() == 0) chk("unexpected1", {ro1, rv1, dn1, er1}, 0);
        else cmp("ev1", q1.pop_front(), mk(cyc, er1 ? 2 : dn1 ? 1 : 0, er1 ? 0 : dn1 ? int'(lr1) : int'(ro1)));
    end

    always @(negedge clk) if (rv3 || dn3 || er3) begin
        chk("excl3", {31'd0, dn3 & er3}, 0);
        if (q3.size() == 0) chk("unexpected3", {ro3, rv3, dn3, er3}, 0);
        else cmp("ev3", q3.pop_front(), mk(cyc, er3 ? 2 : dn3 ? 1 : 0, er3 ? 0 : dn3 ? int'(lr3) : int'(ro3)));
    end

    initial begin
        int s;
        for (int i = 0; i < 128; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_out1", {ra1, ro1, rv1, bz1, dn1, lr1, er1}, 0);
        chk("rst_out3", {ra3, ro3, rv3, bz3, dn3, lr3, er3}, 0);
        reset = 0;
        // basic 4-address play
        mem[5] = {4'h0, 7'd5, 10'd10, 10'd13, 1'b0};
        go(0, 5, s); push_play(0, s, 10, 13, 1, 1, 0); wait_idle(0);
        // rejected entries: seqNum mismatch, nonzero pad, first>last
        mem[5] = {4'h0, 7'd6, 10'd10, 10'd13, 1'b0};
        go(0, 5, s); push(0, mk(s + 3, 2, 0)); repeat (3) @(negedge clk); chk("err_busy_seq", {31'd0, bz1}, 0);
        mem[5] = {4'h1, 7'd5, 10'd10, 10'd13, 1'b0};
        go(0, 5, s); push(0, mk(s + 3, 2, 0)); repeat (3) @(negedge clk); chk("err_busy_pad", {31'd0, bz1}, 0);
        mem[5] = {4'h0, 7'd5, 10'd20, 10'd19, 1'b0};
        go(0, 5, s); push(0, mk(s + 3, 2, 0)); repeat (3) @(negedge clk); chk("err_busy_ord", {31'd0, bz1}, 0);
        // start while busy is ignored (entry 5 would raise error if accepted)
        mem[8] = {4'h0, 7'd8, 10'd100, 10'd105, 1'b1};
        go(0, 8, s); push_play(0, s, 100, 105, 1, 1, 1);
        repeat (5) @(negedge clk);
        seqSel = 5; start1 = 1; @(negedge clk); start1 = 0;
        wait_idle(0);
        // top of ROM space: no wrap, address holds afterwards
        mem[9] = {4'h0, 7'd9, 10'd1021, 10'd1023, 1'b1};
        go(0, 9, s); push_play(0, s, 1021, 1023, 1, 1, 1); wait_idle(0);
        chk("hold_1023", {22'd0, ro1}, 1023);
        chk("hold_valid", {31'd0, rv1}, 0);
        // single address
        mem[10] = {4'h0, 7'd10, 10'd0, 10'd0, 1'b0};
        go(0, 10, s); push_play(0, s, 0, 0, 1, 1, 0); wait_idle(0);
        // reset mid-PLAY at romAddr=12
        mem[5] = {4'h0, 7'd5, 10'd10, 10'd13, 1'b0};
        go(0, 5, s);
        for (int a = 10; a <= 12; a++) push(0, mk(s + 4 + a - 10, 0, a));
        repeat (5) @(negedge clk);
        #1 reset = 1;
        #1 chk("rst_mid1", {ra1, ro1, rv1, bz1, dn1, lr1, er1}, 0);
        @(negedge clk); reset = 0;
        go(0, 5, s); push_play(0, s, 10, 13, 1, 1, 0); wait_idle(0);
        // STEP_DIV=3 instance
        mem[11] = {4'h0, 7'd11, 10'd7, 10'd7, 1'b1};
        go(1, 11, s); push_play(1, s, 7, 7, 3, 1, 1); wait_idle(1);
        mem[12] = {4'h0, 7'd12, 10'd50, 10'd51, 1'b0};
        go(1, 12, s); push_play(1, s, 50, 51, 3, 1, 0); wait_idle(1);
`ifdef TAGLIST_PLAYER_LOOP_EN
        mem[13] = {4'h0, 7'd13, 10'd2, 10'd3, 1'b0};
        loop = 1;
        go(0, 13, s); push_play(0, s, 2, 3, 1, 3, 0);
        repeat (7) @(negedge clk);
        loop = 0;
        wait_idle(0);
`endif
        repeat (3) @(negedge clk);
        chk("q1_empty", q1.size(), 0);
        chk("q3_empty", q3.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
